// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor transmitter model.
package sensor_pkg;
  typedef enum logic [1:0] {IDLE, CONV, READY} sensor_state_t;
  typedef enum logic {GEN_INC, GEN_LFSR} gen_mode_t;

  localparam int              SENSOR_W  = 32;
  localparam logic [SENSOR_W-1:0] LFSR_POLY = 32'h80200003;

  // Galois shift-right step: feed the dropped lsb back through the taps.
  function automatic logic [SENSOR_W-1:0] lfsr_step(input logic [SENSOR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
  endfunction
endpackage

// File: rtl/sensor_pattern_gen.sv
// Deterministic sample source: incrementing counter or Galois LFSR.
module sensor_pattern_gen
  import sensor_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  gen_mode_t           mode,
  input  logic [SENSOR_W-1:0] seed,
  input  logic                load,
  input  logic                advance,
  output logic [SENSOR_W-1:0] value
);
  localparam logic [SENSOR_W-1:0] ONE = {{(SENSOR_W-1){1'b0}}, 1'b1};

  logic [SENSOR_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)
      // An all-zero LFSR would lock up, so it is started at 1 instead.
      value_d = (mode == GEN_LFSR && seed == '0) ? ONE : seed;
    else if (advance)
      value_d = (mode == GEN_LFSR) ? lfsr_step(value_q) : value_q + ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;
endmodule

// File: rtl/sensor_model_tx.sv
// Sensor-side transmitter: one sample per request after CONV_CYCLES of conversion.
module sensor_model_tx
  import sensor_pkg::*;
#(
  parameter int CONV_CYCLES = 4,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sensor_en,
  input  logic              cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic              cfg_load,
  output logic              sensor_ready,
  output logic [DATA_W-1:0] sensor_out,
  output logic [15:0]       sample_cnt,
  output logic              busy
);
  localparam logic [7:0] CONV_RELOAD = 8'(CONV_CYCLES - 1);

  sensor_state_t       state_q, state_d;
  logic [7:0]          conv_cnt_q, conv_cnt_d;
  logic [15:0]         sample_cnt_q, sample_cnt_d;
  logic [DATA_W-1:0]   out_q, out_d;
  gen_mode_t           mode_q, mode_d, gen_mode;
  logic                seeded_q;
  logic                handshake, gen_advance, gen_load;
  logic [SENSOR_W-1:0] gen_value;

  assign handshake = (state_q == READY) && sensor_en;
  // Mode is only followed while idle; mid-stream changes wait for the next IDLE.
  assign gen_mode  = (state_q == IDLE) ? gen_mode_t'(cfg_mode) : mode_q;
  assign gen_load  = cfg_load || !seeded_q;

  always_comb begin
    state_d      = state_q;
    conv_cnt_d   = conv_cnt_q;
    sample_cnt_d = sample_cnt_q;
    out_d        = out_q;
    mode_d       = mode_q;
    gen_advance  = 1'b0;
    if (state_q == IDLE) mode_d = gen_mode_t'(cfg_mode);
    if (cfg_load) begin
      state_d      = IDLE;
      sample_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (sensor_en) begin
          state_d    = CONV;
          conv_cnt_d = CONV_RELOAD;
        end
        CONV: if (!sensor_en) begin
          state_d = IDLE;
        end else if (conv_cnt_q == '0) begin
          state_d = READY;
          out_d   = gen_value;
        end else begin
          conv_cnt_d = conv_cnt_q - 8'd1;
        end
        READY: if (handshake) begin
          gen_advance  = 1'b1;
          sample_cnt_d = sample_cnt_q + 16'd1;
          state_d      = CONV;
          conv_cnt_d   = CONV_RELOAD;
        end else begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      conv_cnt_q   <= '0;
      sample_cnt_q <= '0;
      out_q        <= '0;
      mode_q       <= GEN_INC;
      seeded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_cnt_q   <= conv_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      out_q        <= out_d;
      mode_q       <= mode_d;
      seeded_q     <= 1'b1;
    end
  end

  sensor_pattern_gen u_gen (
    .clk     (clk),
    .rstn    (rstn),
    .mode    (gen_mode),
    .seed    (cfg_seed),
    .load    (gen_load),
    .advance (gen_advance),
    .value   (gen_value)
  );

  assign sensor_ready = handshake;
  assign sensor_out   = out_q;
  assign sample_cnt   = sample_cnt_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: doc/sensor_model_tx.md
Name: sensor_model_tx

Overview:
- Behavioural-synthesizable high-speed sensor transmitter. It is the producing end of the sensor_en / sensor_ready / sensor_out interface that the sensor controller consumes.
- On request it emits one 32-bit sample after a programmable conversion latency.
- Sample data comes from a deterministic generator (incrementing counter or LFSR), so benches and FPGA bring-up can check the captured buffer exactly.
- Sits at system-test level, directly wired to the sensor controller's sensor-side ports.

Parameters:
- CONV_CYCLES, 4, cycles from start of a conversion to its sample being presented (legal range 1..255).
- DATA_W, 32, sample width (fixed at 32 for this interface).

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous active-low
- sensor_en  input  1  request from controller; high = keep converting
- cfg_mode  input  1  0 = incrementing counter, 1 = LFSR; sampled only in IDLE
- cfg_seed  input  32  generator start value; loaded on reset release and on cfg_load
- cfg_load  input  1  one-cycle pulse; reloads generator from cfg_seed and clears sample_cnt
- sensor_ready  output  1  sample valid this cycle
- sensor_out  output  32  sample data; meaningful only while sensor_ready = 1
- sample_cnt  output  16  number of samples delivered, wraps 0xFFFF -> 0x0000
- busy  output  1  high in CONV or READY

Behaviour:
- Reset values (rstn low, asynchronous):
  - state = IDLE; sensor_ready = 0; sensor_out = 0; sample_cnt = 0; busy = 0.
  - Conversion counter = 0; generator = 0, then loaded with cfg_seed on the first clock after release.
- FSM states and transitions:
  - IDLE: if sensor_en = 1, go to CONV and load the conversion counter with CONV_CYCLES-1.
  - CONV: counter decrements each cycle. When it is 0, go to READY.
  - CONV abort: if sensor_en = 0 in any CONV cycle, go to IDLE. No sample is produced and the generator does not advance.
  - READY: exactly one cycle.
    - sensor_ready = state==READY && sensor_en (combinational gate on a registered state).
    - sensor_out holds the generator value, registered, stable for the whole READY cycle.
  - Leaving READY:
    - If sensor_ready was 1: the generator advances and sample_cnt increments. Next state is CONV (counter reloaded) if sensor_en = 1, else IDLE.
    - If sensor_en = 0 in READY: the sample is dropped and the generator holds. Next state is IDLE.
- Throughput: sustained sensor_en gives one sample every CONV_CYCLES+1 cycles. The first sensor_ready arrives CONV_CYCLES+1 cycles after the first sensor_en-high edge.
- Generator:
  - Mode 0: value <= value + 1, modulo 2^32; 0xFFFFFFFF wraps to 0.
  - Mode 1: 32-bit Galois LFSR, shift right. If the lsb is 1, XOR with 0x80200003.
  - A zero seed in mode 1 is replaced by 0x00000001.
- cfg_load:
  - In IDLE: takes effect that cycle.
  - In CONV/READY: the reload is applied in the same cycle and the FSM returns to IDLE. The in-flight sample is discarded.
  - cfg_load simultaneous with a READY handshake: the reload wins, and sample_cnt = 0, not 1.
- cfg_mode changes outside IDLE are ignored until the next IDLE.
- The controller's sctrl_clear drops sensor_en, so it is covered by the abort rules. The controller's full flag likewise drops sensor_en; no sample is emitted after it.
- Reset asserted mid-conversion: all state returns to reset values immediately; there is no partial output.

Decomposition:
- Package sensor_pkg:
  - typedef enum logic [1:0] {IDLE, CONV, READY} sensor_state_t
  - typedef enum logic {GEN_INC, GEN_LFSR} gen_mode_t
  - localparam LFSR_POLY = 32'h80200003
  - localparam SENSOR_W = 32
- Sub-module sensor_pattern_gen: owns the generator register. Its inputs are mode, seed, load, and advance; its output is value.
- The FSM, conversion counter, and sample_cnt live in sensor_model_tx.

Test Plan:
- Counter sequence: CONV_CYCLES=4, mode 0, seed 0x00000010, sensor_en held high 20 cycles -> sensor_ready pulses at cycles 5, 10, 15, 20. sensor_out = 0x10, 0x11, 0x12, 0x13; sample_cnt = 4.
- LFSR sequence: mode 1, seed 0x00000001 -> first two samples 0x00000001 and 0x80200003. Seed 0 -> first sample 0x00000001.
- Abort: sensor_en high 2 cycles, then low -> no sensor_ready. Re-enable gives first sample = the original seed, sample_cnt = 0 before it.
- Drop in READY: sensor_en falls on the READY cycle -> sensor_ready stays 0 and sample_cnt is unchanged. The next accepted sample repeats the same value.
- End-to-end with the sensor controller: 64 accepted samples, mode 0, seed 0 -> sctrl_interrupt asserts. The controller buffer holds 0..63 at addresses 0..63, sensor_en drops, and no further sensor_ready occurs.
- Reset/cfg_load mid-stream:
  - rstn low during CONV -> sensor_ready = 0, sensor_out = 0, sample_cnt = 0 immediately.
  - cfg_load coinciding with a READY handshake -> sample_cnt = 0, FSM in IDLE next cycle.
